// File: rtl/ld_reg_arbiter_pkg.sv
// rtl/ld_reg_arbiter_pkg.sv - shared FSM encoding, default widths and one-hot helper
package ld_reg_arbiter_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOAD = 1'b1;

    localparam int LD_DW = 16;
    localparam int LD_AW = 3;

    // Indices at or beyond width give an all-zero vector.
    function automatic logic [31:0] onehot(input int unsigned idx, input int unsigned width);
        onehot = '0;
        if (idx < width && idx < 32)
            onehot = 32'd1 << idx[4:0];
    endfunction

endpackage

// File: rtl/ld_reg_arbiter_rr_pick.sv
// rtl/ld_reg_arbiter_rr_pick.sv - round-robin winner pick, combinational
module ld_reg_arbiter_rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   winner,
    output logic            any_req
);

    logic [2*NREQ-1:0] dbl;
    logic [2*NREQ-1:0] masked;

    // Lower copy masked below ptr, upper copy unmasked, so the lowest set bit wraps.
    always_comb begin
        dbl    = {req, req};
        masked = '0;
        for (int i = 0; i < 2*NREQ; i++)
            masked[i] = (i >= int'(ptr)) ? dbl[i] : 1'b0;
        winner = '0;
        for (int i = 2*NREQ-1; i >= 0; i--)
            if (masked[i])
                winner = PW'(i % NREQ);
    end

    assign any_req = |req;

endmodule

// File: rtl/ld_reg_arbiter.sv
// rtl/ld_reg_arbiter.sv - round-robin write arbiter driving a loadable register bank
module ld_reg_arbiter
    import ld_reg_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int NREG = 8,
    parameter int AW   = LD_AW,
    parameter int DW   = LD_DW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    gnt,
    output logic [NREG-1:0]    ld,
    output logic [DW-1:0]      wr_data,
    output logic               busy,
    output logic               err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [0:0]    state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] win_q;
    logic [PW-1:0] pick;
    logic          any_req;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;

    ld_reg_arbiter_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .req     (req),
        .ptr     (ptr),
        .winner  (pick),
        .any_req (any_req)
    );

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick == PW'(i)) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            win_q   <= '0;
            gnt     <= '0;
            ld      <= '0;
            wr_data <= '0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state   <= ST_LOAD;
                        busy    <= 1'b1;
                        win_q   <= pick;
                        wr_data <= sel_data;
                        gnt     <= NREQ'(onehot(32'(pick), NREQ));
                        // An address outside the bank is flagged instead of strobed.
                        if (32'(sel_addr) < NREG) begin
                            ld  <= NREG'(onehot(32'(sel_addr), NREG));
                            err <= 1'b0;
                        end else begin
                            ld  <= '0;
                            err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    gnt   <= '0;
                    ld    <= '0;
                    err   <= 1'b0;
                    ptr   <= (win_q == PW'(NREQ-1)) ? '0 : win_q + 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ld_reg_arbiter.sv
// tb/tb_ld_reg_arbiter.sv - scoreboard bench for ld_reg_arbiter
module tb_ld_reg_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  req_a = '0, req_b = '0;
    logic [11:0] addr_a = '0, addr_b = '0;
    logic [63:0] data_a = '0, data_b = '0;
    logic [3:0]  gnt_a, gnt_b;
    logic [7:0]  ld_a;
    logic [5:0]  ld_b;
    logic [15:0] wr_a, wr_b;
    logic        busy_a, busy_b, err_a, err_b;

    ld_reg_arbiter #(.NREQ(4), .NREG(8), .AW(3), .DW(16)) dut_a (
        .clk(clk), .reset(reset), .req(req_a), .req_addr(addr_a), .req_data(data_a),
        .gnt(gnt_a), .ld(ld_a), .wr_data(wr_a), .busy(busy_a), .err(err_a)
    );

    ld_reg_arbiter #(.NREQ(4), .NREG(6), .AW(3), .DW(16)) dut_b (
        .clk(clk), .reset(reset), .req(req_b), .req_addr(addr_b), .req_data(data_b),
        .gnt(gnt_b), .ld(ld_b), .wr_data(wr_b), .busy(busy_b), .err(err_b)
    );

    typedef struct packed {
        logic [3:0]  gnt;
        logic [7:0]  ld;
        logic [15:0] data;
        logic        err;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int total = 0;
    int passed = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    endtask

    function automatic exp_t mk(input logic [3:0] g, input logic [7:0] l,
                                input logic [15:0] d, input logic e);
        exp_t x;
        x.gnt = g; x.ld = l; x.data = d; x.err = e;
        return x;
    endfunction

    task automatic set_a(input int i, input logic [2:0] a, input logic [15:0] d);
        addr_a[i*3 +: 3] = a;
        data_a[i*16 +: 16] = d;
    endtask

    task automatic set_b(input int i, input logic [2:0] a, input logic [15:0] d);
        addr_b[i*3 +: 3] = a;
        data_b[i*16 +: 16] = d;
    endtask

    task automatic wait_gnt(input bit use_b, input string name, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((use_b ? gnt_b : gnt_a) == 4'd0) && n < 20);
        if ((use_b ? gnt_b : gnt_a) == 4'd0) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_queue_empty"}, 32'(qa.size() + qb.size()), 32'd0);
    endtask

    // Monitors: every grant pops one expectation; strobes outside a grant are errors.
    always @(negedge clk) begin
        if (!reset) begin
            if (gnt_a != 4'd0) begin
                if (qa.size() == 0) chk("a_unexpected_gnt", 32'(gnt_a), 32'd0);
                else begin
                    ea = qa.pop_front();
                    chk("a_gnt", 32'(gnt_a), 32'(ea.gnt));
                    chk("a_ld", 32'(ld_a), 32'(ea.ld));
                    chk("a_wr_data", 32'(wr_a), 32'(ea.data));
                    chk("a_err", 32'(err_a), 32'(ea.err));
                    chk("a_busy", 32'(busy_a), 32'd1);
                end
            end else if (ld_a != 8'd0 || busy_a || err_a)
                chk("a_idle_strobes", 32'({ld_a, busy_a, err_a}), 32'd0);
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (gnt_b != 4'd0) begin
                if (qb.size() == 0) chk("b_unexpected_gnt", 32'(gnt_b), 32'd0);
                else begin
                    eb = qb.pop_front();
                    chk("b_gnt", 32'(gnt_b), 32'(eb.gnt));
                    chk("b_ld", 32'(ld_b), 32'(eb.ld));
                    chk("b_wr_data", 32'(wr_b), 32'(eb.data));
                    chk("b_err", 32'(err_b), 32'(eb.err));
                    chk("b_busy", 32'(busy_b), 32'd1);
                end
            end else if (ld_b != 6'd0 || busy_b || err_b)
                chk("b_idle_strobes", 32'({ld_b, busy_b, err_b}), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int t[5];

        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(gnt_a), 32'd0);
        chk("rst_ld", 32'(ld_a), 32'd0);
        chk("rst_wr_data", 32'(wr_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_err", 32'(err_a), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // single write
        set_a(0, 3'd3, 16'hBEEF);
        qa.push_back(mk(4'b0001, 8'b0000_1000, 16'hBEEF, 1'b0));
        req_a = 4'b0001;
        wait_gnt(1'b0, "t1", n);
        chk("t1_latency", 32'(n), 32'd1);
        req_a = 4'b0000;
        @(negedge clk);
        chk("t1_gnt_clear", 32'(gnt_a), 32'd0);
        chk("t1_ld_clear", 32'(ld_a), 32'd0);
        chk("t1_busy_clear", 32'(busy_a), 32'd0);

        // round robin from ptr=0 with all requesters held
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        set_a(0, 3'd4, 16'h1111);
        set_a(1, 3'd5, 16'h2222);
        set_a(2, 3'd6, 16'h3333);
        set_a(3, 3'd7, 16'h4444);
        qa.push_back(mk(4'b0001, 8'h10, 16'h1111, 1'b0));
        qa.push_back(mk(4'b0010, 8'h20, 16'h2222, 1'b0));
        qa.push_back(mk(4'b0100, 8'h40, 16'h3333, 1'b0));
        qa.push_back(mk(4'b1000, 8'h80, 16'h4444, 1'b0));
        qa.push_back(mk(4'b0001, 8'h10, 16'h1111, 1'b0));
        req_a = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(1'b0, "t2", n);
            t[k] = cyc;
            if (k > 0) chk("t2_spacing", 32'(t[k] - t[k-1]), 32'd2);
        end
        req_a = 4'b0000;
        drain("t2");

        // fairness: requester 2 wins, then 0 beats 2 after wrap
        set_a(2, 3'd2, 16'hA5A5);
        qa.push_back(mk(4'b0100, 8'h04, 16'hA5A5, 1'b0));
        req_a = 4'b0100;
        wait_gnt(1'b0, "t3a", n);
        req_a = 4'b0000;
        @(negedge clk);
        set_a(0, 3'd1, 16'h0A0A);
        set_a(2, 3'd2, 16'h2C2C);
        qa.push_back(mk(4'b0001, 8'h02, 16'h0A0A, 1'b0));
        qa.push_back(mk(4'b0100, 8'h04, 16'h2C2C, 1'b0));
        req_a = 4'b0101;
        wait_gnt(1'b0, "t3b", n);
        req_a = 4'b0100;
        wait_gnt(1'b0, "t3c", n);
        req_a = 4'b0000;
        drain("t3");

        // out-of-range address on the NREG=6 instance
        set_b(0, 3'd7, 16'h7777);
        qb.push_back(mk(4'b0001, 8'h00, 16'h7777, 1'b1));
        req_b = 4'b0001;
        wait_gnt(1'b1, "t4a", n);
        req_b = 4'b0000;
        @(negedge clk);
        set_b(1, 3'd5, 16'h5A5A);
        qb.push_back(mk(4'b0010, 8'h20, 16'h5A5A, 1'b0));
        req_b = 4'b0011;
        wait_gnt(1'b1, "t4b", n);
        req_b = 4'b0000;
        drain("t4");

        // reset during LOAD
        set_a(0, 3'd2, 16'h5555);
        qa.push_back(mk(4'b0001, 8'h04, 16'h5555, 1'b0));
        req_a = 4'b0001;
        wait_gnt(1'b0, "t5", n);
        #1 reset = 1'b1;
        #1;
        chk("t5_async_ld", 32'(ld_a), 32'd0);
        chk("t5_async_gnt", 32'(gnt_a), 32'd0);
        chk("t5_async_busy", 32'(busy_a), 32'd0);
        req_a = 4'b0000;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5_post_gnt", 32'(gnt_a), 32'd0);
        chk("t5_post_ld", 32'(ld_a), 32'd0);
        chk("t5_post_wr_data", 32'(wr_a), 32'd0);
        chk("t5_post_busy", 32'(busy_a), 32'd0);
        set_a(0, 3'd0, 16'h1234);
        set_a(3, 3'd7, 16'h4321);
        qa.push_back(mk(4'b0001, 8'h01, 16'h1234, 1'b0));
        qa.push_back(mk(4'b1000, 8'h80, 16'h4321, 1'b0));
        req_a = 4'b1001;
        wait_gnt(1'b0, "t5b", n);
        req_a = 4'b1000;
        wait_gnt(1'b0, "t5c", n);
        req_a = 4'b0000;
        drain("t5");

        // request dropped during LOAD
        set_a(1, 3'd6, 16'h6666);
        qa.push_back(mk(4'b0010, 8'h40, 16'h6666, 1'b0));
        req_a = 4'b0010;
        @(posedge clk);
        #1 req_a = 4'b0000;
        wait_gnt(1'b0, "t6", n);
        repeat (4) @(negedge clk);
        chk("t6_wr_data_hold", 32'(wr_a), 32'h6666);
        drain("t6");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ld_reg_arbiter.md
Name: ld_reg_arbiter

Overview:
Round-robin write arbiter that lets NREQ requesters share a bank of NREG 16-bit loadable registers.
- Each requester presents a register address and write data on a req/gnt handshake.
- The block drives one common write-data bus and one one-hot load strobe per register.
- It sits between the requesting controllers and the register bank; each bank register takes wr_data on its D input and its bit of ld on its load input.

Parameters:
NREQ, 4, number of requesters (2..8)
NREG, 8, number of registers in the bank
AW, 3, register address width; must satisfy 2**AW >= NREG
DW, 16, data width

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
req  input  NREQ  per-requester request, level; held until gnt is seen
req_addr  input  NREQ*AW  requester i address in bits [i*AW +: AW]
req_data  input  NREQ*DW  requester i data in bits [i*DW +: DW]
gnt  output  NREQ  one-hot grant pulse, one cycle, marks write commit
ld  output  NREG  one-hot load strobe to the register bank, one cycle
wr_data  output  DW  shared write data to all bank D inputs
busy  output  1  high while the FSM is in LOAD
err  output  1  one-cycle pulse when the granted address is >= NREG

Behaviour:
Reset
- Asynchronous reset clears gnt, ld, wr_data, busy and err to 0, clears ptr to 0, and puts the FSM in IDLE.
- Reset asserted during LOAD kills the ld strobe immediately; no write occurs and no gnt is given.

Registered outputs and FSM
- All outputs come straight from flops.
- Two states: IDLE and LOAD.

IDLE
- If req == 0: stay in IDLE; all strobes stay 0.
- If any req bit is set:
  - winner = first set bit scanning upward from ptr, wrapping at NREQ.
  - Latch the winner's req_addr/req_data into wr_data, ld, gnt and err on this edge, then go to LOAD.
  - ld[addr] = 1 only if addr < NREG; otherwise ld = 0 and err = 1.

LOAD
- Lasts exactly one cycle. busy = 1; gnt[winner] = 1; ld and wr_data are valid.
- The bank captures wr_data at the edge that ends LOAD.
- On that edge: ptr <= (winner+1) mod NREQ; clear gnt, ld and err to 0; go to IDLE.
- wr_data holds its last value after LOAD; it is only meaningful while ld is set.

Latency and throughput
- req sampled high at edge k gives gnt/ld high in cycle k..k+1, and the register updates at edge k+1.
- Maximum throughput is one write per 2 cycles.

Handshake
- The requester must drop req, or present a new request, at the edge where it samples gnt.
- A req still high in the following IDLE cycle is treated as a new write.
- Once latched, address and data are fixed. Dropping req during LOAD does not cancel the write.

Fairness
- The last winner gets lowest priority next time.
- A continuously requesting requester waits at most NREQ-1 grants.

Simultaneous requests
- Only one grant per LOAD.
- Losers keep req asserted and are served in round-robin order.

Other invariants
- ld and gnt are never multi-hot.
- ld is never high outside LOAD.
- ld is never high when err = 1.

Decomposition:
Shared package holds:
- FSM state encoding ST_IDLE=1'b0, ST_LOAD=1'b1
- default widths DW=16, AW=3
- function onehot(idx, width)

One combinational sub-module, rr_pick:
- Inputs: req vector, ptr.
- Outputs: winner index and any_req.
- Uses a double-width masked priority scan.
- Reused by later arbiters in the design.

Test Plan:
1. Reset then single write: req=4'b0001, req_addr[0]=3, req_data[0]=16'hBEEF → one cycle later ld=8'b0000_1000, wr_data=16'hBEEF, gnt=4'b0001, busy=1; all return to 0 the next cycle.
2. Round-robin: all four req held with data 16'h1111/2222/3333/4444 from reset (ptr=0) → grants in order 0,1,2,3,0, spaced 2 cycles apart; wr_data follows the matching data.
3. Fairness after a win: requester 2 wins; then req=4'b0101 → requester 0 is granted before requester 2 (ptr=3 wraps to 0).
4. Out-of-range address: with NREG=6, req_addr=7 → gnt pulse with err=1, ld=0; ptr advances normally.
5. Reset mid-LOAD: assert reset during the cycle where ld=8'b0000_0100 → ld, gnt and busy drop asynchronously; after release with req=0, outputs stay 0 and ptr=0.
6. Request dropped in LOAD: req deasserted in the LOAD cycle → write still completes with the latched data; no second grant follows.
